// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_arbiter
// Purpose  : Two-port round-robin arbiter serving 32-bit big-endian word reads
//            from a byte-wide parallel flash. Optional macro FLASH_WORD_BUF_EN
//            adds a one-entry word buffer.
// Revision : 1.0 - initial release
// ============================================================================
module flash_read_arbiter #(
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req0,
  input  logic [19:0] addr0,
  output logic        ack0,
  input  logic        req1,
  input  logic [19:0] addr1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N
);

  localparam logic [7:0] c_cnt_reload = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_grant, r_port;
  logic [19:0] r_wa;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_cnt;
  logic [31:0] r_asm;
  logic        w_grant_vld, w_grant_port, w_tie, w_hit, w_cnt_zero, w_byte_last;
  logic [19:0] w_grant_addr;

`ifdef FLASH_WORD_BUF_EN
  logic [19:0] r_buf_addr;
  logic [31:0] r_buf_data;
  logic        r_buf_valid;
`endif

  assign FL_WE_N = 1'b1;

  always_comb begin
    w_grant_vld  = req0 | req1;
    w_tie        = req0 & req1;
    w_grant_port = 1'b0;
    if (w_tie)
      w_grant_port = ~r_last_grant;
    else if (req1)
      w_grant_port = 1'b1;
    w_grant_addr = w_grant_port ? addr1 : addr0;
`ifdef FLASH_WORD_BUF_EN
    w_hit = r_buf_valid && (w_grant_addr == r_buf_addr);
`else
    w_hit = 1'b0;
`endif
    w_cnt_zero  = (r_cnt == 8'd0);
    w_byte_last = (r_byte_idx == 2'd3);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = w_hit ? S_DONE : S_READ;
      S_READ:  if (w_cnt_zero && w_byte_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_wa         <= '0;
      r_byte_idx   <= '0;
      r_cnt        <= '0;
      r_asm        <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      FL_ADDR      <= '0;
      FL_CE_N      <= 1'b1;
      FL_OE_N      <= 1'b1;
      FL_RST_N     <= 1'b0;
`ifdef FLASH_WORD_BUF_EN
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_buf_valid  <= 1'b0;
`endif
    end else begin
      FL_RST_N <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_port     <= w_grant_port;
            r_wa       <= w_grant_addr;
            r_byte_idx <= 2'd0;
            r_cnt      <= c_cnt_reload;
            // Round-robin pointer only moves when both ports contend
            if (w_tie) r_last_grant <= w_grant_port;
`ifdef FLASH_WORD_BUF_EN
            if (w_hit) begin
              r_asm <= r_buf_data;
            end else begin
              FL_ADDR <= {w_grant_addr, 2'b00};
              FL_CE_N <= 1'b0;
              FL_OE_N <= 1'b0;
            end
`else
            FL_ADDR <= {w_grant_addr, 2'b00};
            FL_CE_N <= 1'b0;
            FL_OE_N <= 1'b0;
`endif
          end
        end
        S_READ: begin
          r_cnt <= r_cnt - 8'd1;
          if (w_cnt_zero) begin
            // Shifting four bytes in lands byte 0 at [31:24]
            r_asm <= {r_asm[23:0], FL_DQ};
            if (w_byte_last) begin
              FL_CE_N <= 1'b1;
              FL_OE_N <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_cnt      <= c_cnt_reload;
              FL_ADDR    <= {r_wa, r_byte_idx + 2'd1};
            end
          end
        end
        S_DONE: begin
          rdata <= r_asm;
          ack0  <= ~r_port;
          ack1  <= r_port;
`ifdef FLASH_WORD_BUF_EN
          r_buf_addr  <= r_wa;
          r_buf_data  <= r_asm;
          r_buf_valid <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read_arbiter
// Purpose  : Directed self-checking bench for flash_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_read_arbiter;

  localparam int WAIT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [19:0] addr0 = '0, addr1 = '0;
  logic        ack0, ack1, busy;
  logic [31:0] rdata;
  logic [21:0] FL_ADDR;
  logic [7:0]  FL_DQ;
  logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flash_read_arbiter #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .FL_ADDR(FL_ADDR), .FL_DQ(FL_DQ),
    .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N), .FL_RST_N(FL_RST_N)
  );

  // Flash contents: three known words, everything else reads as zero
  logic [31:0] w_word;
  always_comb begin
    case (FL_ADDR[21:2])
      20'h00000: w_word = 32'h3C1D0000;
      20'h00001: w_word = 32'h27BDFFF0;
      20'hFFFFF: w_word = 32'hDEADBEEF;
      default:   w_word = 32'h00000000;
    endcase
    case (FL_ADDR[1:0])
      2'd0:    FL_DQ = w_word[31:24];
      2'd1:    FL_DQ = w_word[23:16];
      2'd2:    FL_DQ = w_word[15:8];
      default: FL_DQ = w_word[7:0];
    endcase
  end

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single-port read; latency counted in rising edges from the request cycle
  task automatic read_word(input bit port, input logic [19:0] a, input logic [31:0] exp_d,
                           input int exp_lat, input bit chk_addr);
    int  cyc;
    bit  ce_seen;
    bit  got;
    cyc = 0; ce_seen = 0; got = 0;
    @(negedge clk);
    if (port) begin req1 = 1'b1; addr1 = a; end
    else      begin req0 = 1'b1; addr0 = a; end
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!FL_CE_N) ce_seen = 1;
      if (chk_addr && (cyc == 1 || cyc == 9 || cyc == 17 || cyc == 25)) begin
        check_value("fl_addr_step", 32'(FL_ADDR), 32'({a, 2'((cyc - 1) / 8)}));
        check_value("ce_oe_low", {30'd0, FL_CE_N, FL_OE_N}, 32'd0);
      end
      if (chk_addr && cyc == 1) check_value("busy_in_read", 32'(busy), 32'd1);
      if ((port ? ack1 : ack0) === 1'b1) begin
        got = 1;
        req0 = 1'b0;
        req1 = 1'b0;
        check_value("latency", cyc, exp_lat);
        check_value("rdata", rdata, exp_d);
        check_value("other_ack_low", 32'(port ? ack0 : ack1), 32'd0);
        check_value("ce_high_at_ack", 32'(FL_CE_N), 32'd1);
      end
    end
    if (!got) check_value("ack_timeout", 32'(cyc), 32'(exp_lat));
    if (!chk_addr) check_value("no_strobe_on_hit", 32'(ce_seen), 32'd0);
  endtask

  // Both ports request; records the order of acks for n completions
  task automatic dual_read(input int n, input bit drop, input string tag);
    int cyc;
    int done;
    bit expect_port;
    cyc = 0; done = 0; expect_port = 1'b0;
    @(negedge clk);
    addr0 = 20'h00000; addr1 = 20'h00001;
    req0 = 1'b1; req1 = 1'b1;
    while (done < n && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack0 && ack1) check_value({tag, "_both_acks"}, 32'd1, 32'd0);
      if (ack0 || ack1) begin
        check_value({tag, "_grant_order"}, 32'(ack1), 32'(expect_port));
        check_value({tag, "_rdata"}, rdata, ack1 ? 32'h27BDFFF0 : 32'h3C1D0000);
        if (drop) begin
          if (ack0) req0 = 1'b0;
          else      req1 = 1'b0;
        end
        expect_port = ~expect_port;
        done++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (done < n) check_value({tag, "_timeout"}, 32'(done), 32'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset values and FL_RST_N release
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_fl_rst_n", 32'(FL_RST_N), 32'd0);
    check_value("rst_ce_oe", {30'd0, FL_CE_N, FL_OE_N}, 32'd3);
    check_value("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    check_value("rst_rdata", rdata, 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_fl_addr", 32'(FL_ADDR), 32'd0);
    check_value("we_n_tied", 32'(FL_WE_N), 32'd1);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("fl_rst_n_release", 32'(FL_RST_N), 32'd1);

    // 2: single port-0 read
    read_word(1'b0, 20'h00000, 32'h3C1D0000, 4 * WAIT_CYCLES + 2, 1'b1);

    // 3: simultaneous requests, each dropped on its ack
    do_reset();
    dual_read(2, 1'b1, "tie");

    // 4: continuous contention alternates 0,1,0,1
    do_reset();
    dual_read(4, 1'b0, "rr");

    // 5: top word address wraps within the byte address space
    do_reset();
    read_word(1'b1, 20'hFFFFF, 32'hDEADBEEF, 4 * WAIT_CYCLES + 2, 1'b1);

    // 6: reset during byte 2 aborts the transaction
    do_reset();
    @(negedge clk);
    req0 = 1'b1; addr0 = 20'h00000;
    repeat (20) @(posedge clk);
    #1;
    check_value("abort_fl_addr_b2", 32'(FL_ADDR), 32'd2);
    Reset_n = 1'b0;
    #1;
    check_value("abort_ce", 32'(FL_CE_N), 32'd1);
    check_value("abort_fl_addr", 32'(FL_ADDR), 32'd0);
    check_value("abort_busy", 32'(busy), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    begin
      bit ack_seen;
      ack_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (ack0 || ack1) ack_seen = 1;
      end
      check_value("abort_no_ack", 32'(ack_seen), 32'd0);
    end
    read_word(1'b0, 20'h00001, 32'h27BDFFF0, 4 * WAIT_CYCLES + 2, 1'b1);

    // 7: reread the same word
    do_reset();
    read_word(1'b0, 20'h00001, 32'h27BDFFF0, 4 * WAIT_CYCLES + 2, 1'b1);
`ifdef FLASH_WORD_BUF_EN
    read_word(1'b1, 20'h00001, 32'h27BDFFF0, 2, 1'b0);
`else
    read_word(1'b1, 20'h00001, 32'h27BDFFF0, 4 * WAIT_CYCLES + 2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
